// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control_if
// Description : Control bus between the multicycle MIPS control unit and its
//               datapath (opcode/ready in, enables and mux selects out).
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    // Control unit side
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    // Datapath side
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Moore control FSM for a multicycle MIPS core; sequences
//               fetch/decode/execute/memory/writeback with memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_multicycle_control_if.master     bus
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    state_t r_state;
    // lw/sw choice is captured at decode so opcode is never looked at again
    logic   r_is_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= state_t'(RESET_STATE);
            r_is_store <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_is_store <= (bus.opcode == c_OP_SW);
                    case (bus.opcode)
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_RTYPE:       r_state <= S_EXEC;
                        c_OP_BEQ:         r_state <= S_BRANCH;
                        c_OP_J:           r_state <= S_JUMP;
                        c_OP_ADDI:        r_state <= S_ADDIEX;
                        default:          r_state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: r_state <= r_is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.mem_ready) r_state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (bus.mem_ready) r_state <= S_FETCH;
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_illegal_op;

    // Pure state decode; rst_n gating keeps every output quiet while in reset
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_illegal_op    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_read  = 1'b1;
                    w_alu_src_b = 2'b01;
                    w_ir_write  = bus.mem_ready;
                    w_pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    w_alu_src_b = 2'b11;
                end
                S_MEMADR, S_ADDIEX: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    w_mem_read = 1'b1;
                    w_i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    w_mem_write = 1'b1;
                    w_i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    w_alu_src_a     = 1'b1;
                    w_alu_op        = 2'b01;
                    w_pc_write_cond = 1'b1;
                    w_pc_source     = 2'b01;
                end
                S_JUMP: begin
                    w_pc_write  = 1'b1;
                    w_pc_source = 2'b10;
                end
                S_ADDIWB: begin
                    w_reg_write = 1'b1;
                end
                S_ILLEGAL: begin
                    w_illegal_op = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.ir_write      = w_ir_write;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.reg_write     = w_reg_write;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.pc_source     = w_pc_source;
    assign bus.illegal_op    = w_illegal_op;
    assign bus.state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Randomized instruction-level bench for the multicycle control
//               FSM against a state-sequence / control-word reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] observed();
        return 32'({bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                    bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.pc_source, bus.illegal_op});
    endfunction

    // Control word each state must present, field by field
    function automatic logic [31:0] expected(input int st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ill} = '0;
        srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return 32'({pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill});
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Called just after a falling edge; leaves time at the next falling edge
    task automatic do_cycle(input int st, input logic rdy, input logic [5:0] op);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        #1;
        check($sformatf("state(st%0d)", st), 32'(bus.state), 32'(st));
        check($sformatf("ctrl(st%0d)", st), observed(), expected(st, rdy));
        @(negedge clk);
    endtask

    // waits < 0 means random memory latency for MEMRD/MEMWR
    task automatic run_instr(input logic [5:0] op, input int waits);
        int seq[$];
        int w;
        seq = '{0, 1};
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 10, 11};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
            default:   seq = '{0, 1, 12};
        endcase
        foreach (seq[k]) begin
            if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) begin
                w = (seq[k] != 0 && waits >= 0) ? waits : int'($urandom_range(0, 2));
                for (int c = 0; c < w; c++) do_cycle(seq[k], 1'b0, 6'($urandom));
                do_cycle(seq[k], 1'b1, 6'($urandom));
            end else if (seq[k] == 1) begin
                do_cycle(1, 1'($urandom), op);
            end else begin
                do_cycle(seq[k], 1'($urandom), 6'($urandom));
            end
        end
    endtask

    function automatic logic [5:0] random_op();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        if ($urandom_range(0, 6) != 6) return ops[$urandom_range(0, 5)];
        do op = 6'($urandom); while (is_legal(op));
        return op;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b100011;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_ctrl", observed(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: lw, sw with 3 waits, R, beq, j, opcode 111111
        run_instr(6'b100011, 0);
        run_instr(6'b101011, 3);
        run_instr(6'b000000, 0);
        run_instr(6'b000100, 0);
        run_instr(6'b000010, 0);
        run_instr(6'b111111, 0);

        // Reset while stalled in MEMRD
        do_cycle(0, 1'b1, 6'd0);
        do_cycle(1, 1'b1, 6'b100011);
        do_cycle(2, 1'b1, 6'd0);
        bus.mem_ready = 1'b0;
        #1;
        check("memrd_state", 32'(bus.state), 32'd3);
        check("memrd_ctrl", observed(), expected(3, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state), 32'd0);
        check("async_rst_ctrl", observed(), 32'd0);
        @(negedge clk);
        #1;
        check("held_rst_ctrl", observed(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'b001000, 0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) run_instr(random_op(), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and writeback for each instruction. It drives every datapath enable and every mux select, including the 2-bit select of the 32-bit 4:1 ALU-B operand mux. Memory accesses use a ready handshake, so the sequence stalls on slow memory.

## Interface
Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); not to be overridden in the core.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  ALU-B 4:1 mux select: 00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2; bit 1 drives the mux's first select, bit 0 the second
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal.
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, ILLEGAL 12. Codes 13–15 go to FETCH on the next edge, with all outputs deasserted.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - otherwise → ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- ILLEGAL: illegal_op=1, no write enables. Goes to FETCH; the PC has already advanced by 4.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational decodes of the state register. The only exceptions are FETCH ir_write and pc_write, which also depend on mem_ready. There is no path from opcode to any output.
- Reset: asserting rst_n low forces state=FETCH immediately, without waiting for a clock edge.
  - While rst_n is low, every output is 0, including mem_read; state reads 0.
  - FETCH outputs appear in the first cycle after rst_n goes high.
  - Reset asserted mid-instruction abandons it with no further writes.
- Cycles per instruction with zero memory wait:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal: 3
- Each memory wait cycle adds one cycle in FETCH, MEMRD or MEMWR.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR and ignored elsewhere. If mem_ready stays 0 indefinitely, the FSM holds its state and outputs stable.
- opcode is sampled only on the DECODE→next edge. The instruction register is stable at that point because ir_write was last asserted in FETCH.

## Test plan
- Reset: hold rst_n=0 across an edge → all outputs 0 and state=0. Release → mem_read=1 and alu_src_b=01 in the next cycle.
- lw with opcode 100011 and mem_ready=1 throughout → state sequence 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 in state 4 only.
- sw with opcode 101011 and mem_ready low for 3 cycles in MEMWR → 3 extra cycles in state 5 with mem_write held at 1, then FETCH.
- R-type, then beq, then j → correct alu_src_b values (00, 11, 00/11) and pc_source values (01 in BRANCH, 10 in JUMP).
- Opcode 111111 → ILLEGAL with illegal_op high for exactly 1 cycle, no write enable asserted, then FETCH.
- Assert rst_n low in MEMRD with mem_ready=0 → outputs drop to 0 asynchronously. After release, FETCH resumes and no reg_write occurs.
